// File: rtl/conv1d_param_coprocessor.sv
// conv1d_param_coprocessor: full linear 1D convolution Z = X * Y (unsigned).
// X and Y come from external synchronous-read RAMs (1-cycle latency).
// Each result is written to an external Z RAM.
// Optional macro CONV_SATURATION_EN clamps dataZ at 2^DATA_WIDTH_Z-1.
// Without it, dataZ is the truncated accumulator.
module conv1d_param_coprocessor #(
  parameter int DATA_WIDTH_X = 8,
  parameter int ADDR_WIDTH_X = 5,
  parameter int DATA_WIDTH_Y = 8,
  parameter int ADDR_WIDTH_Y = 5,
  parameter int DATA_WIDTH_Z = 16,
  parameter int ADDR_WIDTH_Z = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH_X-1:0] sizeX,
  input  logic [ADDR_WIDTH_Y-1:0] sizeY,
  input  logic [DATA_WIDTH_X-1:0] dataX,
  input  logic [DATA_WIDTH_Y-1:0] dataY,
  output logic [ADDR_WIDTH_X-1:0] memX_addr,
  output logic [ADDR_WIDTH_Y-1:0] memY_addr,
  output logic [DATA_WIDTH_Z-1:0] dataZ,
  output logic [ADDR_WIDTH_Z-1:0] memZ_addr,
  output logic                    writeZ,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int PW = DATA_WIDTH_X + DATA_WIDTH_Y;
  localparam int AW = PW + ADDR_WIDTH_X;
  localparam int MW = (ADDR_WIDTH_X > ADDR_WIDTH_Y) ? ADDR_WIDTH_X : ADDR_WIDTH_Y;
  // Index width is wide enough for L and for the Z RAM depth 2^ADDR_WIDTH_Z.
  localparam int CW = ((MW > ADDR_WIDTH_Z) ? MW : ADDR_WIDTH_Z) + 2;
  localparam logic [CW-1:0] Z_DEPTH = {{(CW-1){1'b0}}, 1'b1} << ADDR_WIDTH_Z;

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, DRAIN, WRITE, DONE} state_t;

  state_t        state;
  logic          prevStart;
  logic [CW-1:0] szX, szY, n, k, kEnd;
  logic [CW-1:0] len, nNext;
  logic [AW-1:0] acc, accNext;
  logic [PW-1:0] prod;
  logic          firstTerm, termVld, termFirst;
  logic [DATA_WIDTH_Z-1:0] zVal;

  // First and last kernel index that overlaps the signal for output nv.
  function automatic logic [CW-1:0] kLo(input logic [CW-1:0] nv, input logic [CW-1:0] sy);
    return (nv >= sy) ? nv - sy + 1'b1 : '0;
  endfunction
  function automatic logic [CW-1:0] kHi(input logic [CW-1:0] nv, input logic [CW-1:0] sx);
    return (nv < sx) ? nv : sx - 1'b1;
  endfunction

  assign len   = szX + szY - 1'b1;
  assign nNext = n + 1'b1;
  assign prod  = {{DATA_WIDTH_Y{1'b0}}, dataX} * {{DATA_WIDTH_X{1'b0}}, dataY};
  // The RAM data for a term arrives one cycle after its address.
  // termFirst restarts the sum for a new output.
  assign accNext = (termFirst ? '0 : acc) + {{ADDR_WIDTH_X{1'b0}}, prod};

`ifdef CONV_SATURATION_EN
  localparam int EW = (AW > DATA_WIDTH_Z) ? AW : DATA_WIDTH_Z;
  logic [EW-1:0] accExt, zMax;
  assign accExt = EW'(accNext);
  assign zMax   = EW'({DATA_WIDTH_Z{1'b1}});
  assign zVal   = (accExt > zMax) ? '1 : DATA_WIDTH_Z'(accExt);
`else
  assign zVal   = DATA_WIDTH_Z'(accNext);
`endif

  // Control FSM with registered outputs, address generation and accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prevStart <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      writeZ    <= 1'b0;
      memX_addr <= '0;
      memY_addr <= '0;
      memZ_addr <= '0;
      dataZ     <= '0;
      szX       <= '0;
      szY       <= '0;
      n         <= '0;
      k         <= '0;
      kEnd      <= '0;
      acc       <= '0;
      firstTerm <= 1'b0;
      termVld   <= 1'b0;
      termFirst <= 1'b0;
    end else begin
      prevStart <= start;
      done      <= 1'b0;
      writeZ    <= 1'b0;
      termVld   <= 1'b0;
      if (termVld) acc <= accNext;
      case (state)
        IDLE: if (start && !prevStart) begin
          state <= CHECK;
          busy  <= 1'b1;
          err   <= 1'b0;
          szX   <= CW'(sizeX);
          szY   <= CW'(sizeY);
        end
        CHECK: begin
          if (szX == '0 || szY == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (len > Z_DEPTH) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            n         <= '0;
            k         <= '0;
            kEnd      <= '0;
            memX_addr <= '0;
            memY_addr <= '0;
            firstTerm <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          termVld   <= 1'b1;
          termFirst <= firstTerm;
          firstTerm <= 1'b0;
          if (k == kEnd) begin
            state <= DRAIN;
          end else begin
            k         <= k + 1'b1;
            memX_addr <= ADDR_WIDTH_X'(k + 1'b1);
            memY_addr <= memY_addr - 1'b1;
          end
        end
        DRAIN: begin
          state     <= WRITE;
          writeZ    <= 1'b1;
          memZ_addr <= ADDR_WIDTH_Z'(n);
          dataZ     <= zVal;
        end
        WRITE: begin
          if (n == len - 1'b1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            n         <= nNext;
            k         <= kLo(nNext, szY);
            kEnd      <= kHi(nNext, szX);
            memX_addr <= ADDR_WIDTH_X'(kLo(nNext, szY));
            memY_addr <= ADDR_WIDTH_Y'(nNext - kLo(nNext, szY));
            firstTerm <= 1'b1;
            state     <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1d_param_coprocessor.sv
// Directed bench for conv1d_param_coprocessor.
// Instance A uses the default parameters.
// Instance B uses ADDR_WIDTH_Z=3 for the Z-overflow rejection.
// Instance C uses DATA_WIDTH_Z=8 for the truncation/saturation check.
module tb_conv1d_param_coprocessor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] start = '0;
  logic [4:0] sizeX = '0, sizeY = '0;
  logic [7:0] mx [32];
  logic [7:0] my [32];

  logic [4:0]  axA, ayA, axB, ayB, axC, ayC;
  logic [7:0]  dxA, dyA, dxB, dyB, dxC, dyC;
  logic [15:0] dzA, dzB;
  logic [7:0]  dzC;
  logic [5:0]  azA, azC;
  logic [2:0]  azB;
  logic [2:0]  wr, busy, done, err;

  conv1d_param_coprocessor dutA (
    .clk(clk), .rst(rst), .start(start[0]), .sizeX(sizeX), .sizeY(sizeY),
    .dataX(dxA), .dataY(dyA), .memX_addr(axA), .memY_addr(ayA),
    .dataZ(dzA), .memZ_addr(azA), .writeZ(wr[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]));

  conv1d_param_coprocessor #(.ADDR_WIDTH_Z(3)) dutB (
    .clk(clk), .rst(rst), .start(start[1]), .sizeX(sizeX), .sizeY(sizeY),
    .dataX(dxB), .dataY(dyB), .memX_addr(axB), .memY_addr(ayB),
    .dataZ(dzB), .memZ_addr(azB), .writeZ(wr[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]));

  conv1d_param_coprocessor #(.DATA_WIDTH_Z(8)) dutC (
    .clk(clk), .rst(rst), .start(start[2]), .sizeX(sizeX), .sizeY(sizeY),
    .dataX(dxC), .dataY(dyC), .memX_addr(axC), .memY_addr(ayC),
    .dataZ(dzC), .memZ_addr(azC), .writeZ(wr[2]), .busy(busy[2]),
    .done(done[2]), .err(err[2]));

  // Synchronous-read RAMs (1-cycle latency), shared contents.
  always @(posedge clk) begin
    dxA <= mx[axA]; dyA <= my[ayA];
    dxB <= mx[axB]; dyB <= my[ayB];
    dxC <= mx[axC]; dyC <= my[ayC];
  end

`ifdef CONV_SATURATION_EN
  localparam logic [7:0] Z0C = 8'd255, Z1C = 8'd255, Z2C = 8'd255;
`else
  localparam logic [7:0] Z0C = 8'd1, Z1C = 8'd2, Z2C = 8'd3;
`endif

  // Z RAM models and write/done monitors.
  int          wrCnt [3] = '{0, 0, 0};
  int          doneCnt [3] = '{0, 0, 0};
  logic [15:0] zA [64];
  logic [15:0] zB [8];
  logic [7:0]  zC [64];
  logic [63:0] maskA = '0;
  longint      sumA = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr[i] === 1'b1) wrCnt[i] <= wrCnt[i] + 1;
      if (done[i] === 1'b1) doneCnt[i] <= doneCnt[i] + 1;
    end
    if (wr[0] === 1'b1) begin
      zA[azA] <= dzA;
      maskA   <= maskA | (64'd1 << azA);
      sumA    <= sumA + longint'(dzA);
    end
    if (wr[1] === 1'b1) zB[azB] <= dzB;
    if (wr[2] === 1'b1) zC[azC] <= dzC;
  end

  int nRun = 0, nFail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nRun++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Produce a fresh start edge and count posedges until done (bounded).
  // The edge that samples start counts as 1. Returns -1 on timeout.
  task automatic runOne(input int sel, output int cyc);
    bit got;
    got = 1'b0;
    start[sel] = 1'b0;
    repeat (3) @(negedge clk);
    start[sel] = 1'b1;
    cyc = 0;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      got = (done[sel] === 1'b1);
    end
    if (!got) cyc = -1;
  endtask

  task automatic loadRamp();
    for (int i = 0; i < 32; i++) begin
      mx[i] = (i < 5)  ? 8'(i + 1) : 8'd0;
      my[i] = (i < 10) ? 8'(i + 1) : 8'd0;
    end
  endtask

  int     cyc, w0, d0;
  longint s0;

  initial begin
    loadRamp();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy[0], 0);
    chk("rst done", done[0], 0);
    chk("rst err", err[0], 0);
    chk("rst writeZ", wr[0], 0);
    chk("rst addrs", {axA, ayA, azA}, 0);
    chk("rst dataZ", dzA, 0);
    @(negedge clk) rst = 1'b0;

    // 1: X=[1..5], Y=[1..10]
    sizeX = 5; sizeY = 10;
    w0 = wrCnt[0]; s0 = sumA;
    runOne(0, cyc);
    chk("t1 latency", cyc, 80);
    chk("t1 busy at done", busy[0], 0);
    chk("t1 err", err[0], 0);
    @(negedge clk);
    chk("t1 writes", wrCnt[0] - w0, 14);
    chk("t1 addr cover", maskA, 64'h3FFF);
    chk("t1 Z0", zA[0], 1);
    chk("t1 Z1", zA[1], 4);
    chk("t1 Z4", zA[4], 35);
    chk("t1 Z13", zA[13], 50);
    chk("t1 sumZ", sumA - s0, 825);

    // 2: empty kernel / empty signal
    sizeX = 0; sizeY = 10;
    w0 = wrCnt[0];
    runOne(0, cyc);
    chk("t2 sx0 latency", cyc, 2);
    chk("t2 sx0 err", err[0], 0);
    sizeX = 5; sizeY = 0;
    runOne(0, cyc);
    chk("t2 sy0 latency", cyc, 2);
    chk("t2 sy0 err", err[0], 0);
    @(negedge clk);
    chk("t2 no writes", wrCnt[0] - w0, 0);

    // 3: Z RAM too small (L=14 > 8), then boundary L=8 clears err
    sizeX = 5; sizeY = 10;
    w0 = wrCnt[1];
    runOne(1, cyc);
    chk("t3 rej latency", cyc, 2);
    chk("t3 rej err", err[1], 1);
    repeat (5) @(negedge clk);
    chk("t3 err held", err[1], 1);
    chk("t3 rej no writes", wrCnt[1] - w0, 0);
    sizeX = 4; sizeY = 5;
    runOne(1, cyc);
    chk("t3 ok err", err[1], 0);
    @(negedge clk);
    chk("t3 ok writes", wrCnt[1] - w0, 8);
    chk("t3 Z2", zB[2], 10);
    chk("t3 Z7", zB[7], 20);

    // 4: 8-bit Z, X=Y=[255,255,255]
    for (int i = 0; i < 3; i++) begin mx[i] = 8'd255; my[i] = 8'd255; end
    sizeX = 3; sizeY = 3;
    w0 = wrCnt[2];
    runOne(2, cyc);
    chk("t4 latency", cyc, 1 + (1 + 2 + 3 + 2 + 1) + 10 + 1);
    @(negedge clk);
    chk("t4 writes", wrCnt[2] - w0, 5);
    chk("t4 Z0", zC[0], Z0C);
    chk("t4 Z1", zC[1], Z1C);
    chk("t4 Z2", zC[2], Z2C);

    // 5: start held across done does not retrigger; fresh edge reruns
    loadRamp();
    sizeX = 5; sizeY = 10;
    w0 = wrCnt[0]; d0 = doneCnt[0];
    runOne(0, cyc);
    chk("t5 latency", cyc, 80);
    repeat (40) @(negedge clk);
    chk("t5 held writes", wrCnt[0] - w0, 14);
    chk("t5 held dones", doneCnt[0] - d0, 1);
    chk("t5 held busy", busy[0], 0);
    w0 = wrCnt[0]; s0 = sumA;
    runOne(0, cyc);
    chk("t5 rerun latency", cyc, 80);
    @(negedge clk);
    chk("t5 rerun writes", wrCnt[0] - w0, 14);
    chk("t5 rerun sumZ", sumA - s0, 825);
    chk("t5 rerun Z4", zA[4], 35);

    // 6: reset mid-run, then a clean run
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    chk("t6 busy", busy[0], 0);
    chk("t6 done", done[0], 0);
    chk("t6 writeZ", wr[0], 0);
    chk("t6 addrs", {axA, ayA, azA}, 0);
    chk("t6 dataZ", dzA, 0);
    w0 = wrCnt[0]; d0 = doneCnt[0];
    @(negedge clk) rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("t6 no writes", wrCnt[0] - w0, 0);
    chk("t6 no done", doneCnt[0] - d0, 0);
    s0 = sumA;
    runOne(0, cyc);
    chk("t6 run latency", cyc, 80);
    @(negedge clk);
    chk("t6 run writes", wrCnt[0] - w0, 14);
    chk("t6 run sumZ", sumA - s0, 825);
    chk("t6 run Z13", zA[13], 50);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule

// File: doc/conv1d_param_coprocessor.md
Name: conv1d_param_coprocessor

Overview:
Parametrised successor of the fixed 1D convolution coprocessor. Computes full linear convolution Z[n] = sum_k X[k]*Y[n-k], n = 0..sizeX+sizeY-2, unsigned.
- Kernel X and signal Y are read from two external synchronous-read RAMs (1-cycle read latency).
- Results are written to an external Z RAM.
- New versus the previous generation: runtime kernel length, generic widths, rising-edge start, error flag on Z overflow, optional saturation.

Parameters:
DATA_WIDTH_X, 8, kernel sample width
ADDR_WIDTH_X, 5, kernel RAM address width; max sizeX = 2^ADDR_WIDTH_X-1
DATA_WIDTH_Y, 8, signal sample width
ADDR_WIDTH_Y, 5, signal RAM address width; max sizeY = 2^ADDR_WIDTH_Y-1
DATA_WIDTH_Z, 16, result width written to Z RAM
ADDR_WIDTH_Z, 6, Z RAM address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  run request; rising edge (start=1, previous sampled start=0) in IDLE begins a run
sizeX  in  ADDR_WIDTH_X  kernel length
sizeY  in  ADDR_WIDTH_Y  signal length
dataX  in  DATA_WIDTH_X  kernel RAM read data, valid 1 cycle after memX_addr
dataY  in  DATA_WIDTH_Y  signal RAM read data, valid 1 cycle after memY_addr
memX_addr  out  ADDR_WIDTH_X  kernel read address
memY_addr  out  ADDR_WIDTH_Y  signal read address
dataZ  out  DATA_WIDTH_Z  result write data
memZ_addr  out  ADDR_WIDTH_Z  result write address
writeZ  out  1  Z RAM write enable, 1-cycle pulse per result
busy  out  1  high from CHECK through final WRITE
done  out  1  1-cycle completion pulse
err  out  1  high with done when run rejected; held until next accepted start

Behaviour:
Reset:
- All outputs 0; FSM to IDLE; previous-start register cleared.
- Reset mid-run aborts at that edge. No further writeZ, no done pulse.
Start handling:
- sizeX/sizeY latched on the start edge.
- start ignored outside IDLE.
- A start held high across done does not retrigger; a fresh 0->1 edge is required.
FSM states: IDLE, CHECK, FETCH, DRAIN, WRITE, DONE.
- IDLE -> CHECK on start rising edge.
- CHECK (1 cycle, busy=1), L = sizeX+sizeY-1:
  - if sizeX==0 or sizeY==0: go to DONE, err=0, no writes.
  - else if L > 2^ADDR_WIDTH_Z: go to DONE, err=1, no writes.
  - else: n=0, go to FETCH.
- FETCH, per output n:
  - k runs kmin = max(0, n-sizeY+1) .. kmax = min(n, sizeX-1).
  - One term per cycle: memX_addr=k, memY_addr=n-k.
  - Product dataX*dataY added to accumulator one cycle later.
  - Accumulator cleared at the first term of each n.
  - After kmax: go to DRAIN.
- DRAIN (1 cycle): last product accumulated.
- WRITE (1 cycle): writeZ=1, memZ_addr=n, dataZ=result.
  - If n==L-1: go to DONE; else n++ and go to FETCH.
- DONE (1 cycle): done=1, busy=0; then IDLE.
Arithmetic:
- Accumulator width DATA_WIDTH_X+DATA_WIDTH_Y+ADDR_WIDTH_X, never overflows internally.
- dataZ = low DATA_WIDTH_Z bits of accumulator (see optional feature).
Latency:
- done is high exactly 1 + sum_n(terms_n + 2) + 1 cycles after the start-edge sampling cycle, i.e. CHECK + work + DONE.
- Total for sizeX=5, sizeY=10 (sum terms = 50, L = 14): 1 + 78 + 1 = 80 cycles.
Other rules:
- memX_addr, memY_addr, memZ_addr hold their last value outside active states.
- dataZ is meaningful only while writeZ=1.

Optional Feature:
Macro CONV_SATURATION_EN.
- Defined: dataZ = 2^DATA_WIDTH_Z-1 when the accumulator exceeds that value, else the accumulator value.
- Undefined: plain truncation to the low DATA_WIDTH_Z bits.

Test Plan:
1. Defaults; X=[1,2,3,4,5], sizeX=5; Y=[1..10], sizeY=10; start edge -> 14 writes, addresses 0..13.
   - Z[0]=1, Z[1]=4, Z[4]=35, Z[13]=50.
   - done exactly 80 cycles after start sampled; busy low again with done.
2. sizeX=0 or sizeY=0 -> done 2 cycles after start, err=0, writeZ never asserted.
3. ADDR_WIDTH_Z=3, sizeX=5, sizeY=10 (L=14>8) -> done 2 cycles after start, err=1, no writes; next valid run clears err.
4. DATA_WIDTH_Z=8; X=Y=[255,255,255], sizes 3; Z[0], Z[2] checked:
   - without macro: Z[0]=1, Z[2]=3.
   - with CONV_SATURATION_EN: Z[0]=255, Z[2]=255.
5. start held high through done, then held 40 cycles -> exactly one run. Drop start then raise it -> second identical run, same Z values.
6. rst asserted on cycle 30 of test 1 -> next cycle all outputs 0, no further writes, no done. New start edge -> full correct run.
